// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared definitions for the asynchronous FIFO control blocks:
//               default address width and Gray/binary pointer conversions.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Default FIFO address width (depth = 2**FIFO_ADDR_W).
  localparam int FIFO_ADDR_W = 4;

  // Working width of the conversion helpers; callers zero-extend their
  // pointer into this width and size-cast the result back down.
  localparam int FIFO_FN_W = 32;

  // Binary to reflected Gray code.
  function automatic logic [FIFO_FN_W-1:0] bin2gray(input logic [FIFO_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB. Zero upper bits
  // leave the narrow result unchanged.
  function automatic logic [FIFO_FN_W-1:0] gray2bin(input logic [FIFO_FN_W-1:0] g);
    logic [FIFO_FN_W-1:0] b;
    b[FIFO_FN_W-1] = g[FIFO_FN_W-1];
    for (int i = FIFO_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop clock-domain-crossing synchronizer. Each bit of d is
//               independently resynchronized into the clk domain; the caller
//               must guarantee that at most one bit changes at a time (Gray
//               coded bus). r_meta is the metastability-capture stage and
//               must be the only flop sampling d.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // CDC stage 1 captures the asynchronous bus, stage 2 filters metastability.
  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back capture flops, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_ctrl
// Description : Write-side controller of an asynchronous FIFO. Maintains the
//               binary and Gray write pointers, synchronizes the Gray read
//               pointer into the write clock domain and derives registered
//               full / almost_full / occupancy flags from next-state values
//               so they move on the same edge as the write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W   = FIFO_ADDR_W,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rptr_gray,
  output logic [ADDR_W:0]   wptr_gray,
  output logic [ADDR_W-1:0] waddr,
  output logic              wr_accept,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PTR_W-1:0] C_AF_LEVEL = PTR_W'(AF_LEVEL);

  // Elaboration-time parameter sanity: the full compare needs two pointer
  // MSBs plus at least one address bit, and AF_LEVEL must be reachable.
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("fifo_wr_ctrl: ADDR_W must be at least 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
    $error("fifo_wr_ctrl: AF_LEVEL must be in 1..DEPTH");
  end

  // Registered state.
  logic [PTR_W-1:0] r_wbin;
  logic [PTR_W-1:0] r_wgray;
  logic             r_full;
  logic             r_almost_full;
  logic [PTR_W-1:0] r_level;
  logic             r_overflow;

  // Combinational next-state terms.
  logic             w_wr_accept;
  logic             w_overflow_set;
  logic [PTR_W-1:0] w_rq_sync;
  logic [PTR_W-1:0] w_rbin_s;
  logic [PTR_W-1:0] w_wbin_next;
  logic [PTR_W-1:0] w_wgray_next;
  logic [PTR_W-1:0] w_full_pattern;
  logic             w_full_next;
  logic [PTR_W-1:0] w_level_next;
  logic             w_almost_full_next;

  // Read pointer crossing: the synchronizer is the only sampler of rptr_gray.
  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray),
    .q   (w_rq_sync)
  );

  // Accept a write only when not full; a write attempted while full is
  // dropped and recorded in the sticky overflow flag.
  assign w_wr_accept    = wr_en & ~r_full;
  assign w_overflow_set = wr_en & r_full;

  // Synchronized read pointer back to binary for the occupancy subtraction.
  assign w_rbin_s = PTR_W'(gray2bin(FIFO_FN_W'(w_rq_sync)));

  // Next write pointer, in binary and Gray.
  assign w_wbin_next  = r_wbin + PTR_W'(w_wr_accept);
  assign w_wgray_next = PTR_W'(bin2gray(FIFO_FN_W'(w_wbin_next)));

  // Full when the write pointer is exactly one lap ahead of the read
  // pointer: in Gray that is the read pointer with its two MSBs inverted.
  assign w_full_pattern = {~w_rq_sync[ADDR_W:ADDR_W-1], w_rq_sync[ADDR_W-2:0]};
  assign w_full_next    = (w_wgray_next == w_full_pattern);

  // Occupancy seen from the write side; modulo arithmetic handles the wrap.
  assign w_level_next       = w_wbin_next - w_rbin_s;
  assign w_almost_full_next = (w_level_next >= C_AF_LEVEL);

  // Pointer and flag registers, all loaded from next-state values so the
  // flags track the pointer on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_level       <= '0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_full        <= w_full_next;
      r_almost_full <= w_almost_full_next;
      r_level       <= w_level_next;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_overflow_set) begin
      r_overflow <= 1'b1;
    end
  end

  assign wptr_gray   = r_wgray;
  assign waddr       = r_wbin[ADDR_W-1:0];
  assign wr_accept   = w_wr_accept;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wr_level    = r_level;
  assign overflow    = r_overflow;

endmodule : fifo_wr_ctrl
`default_nettype wire

// File: tb/tb_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_ctrl
// Description : Self-checking bench for fifo_wr_ctrl (ADDR_W=4, AF_LEVEL=12).
//               Reference model counts writes and reads as plain integers and
//               remembers the read count offered at each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_ctrl;

  localparam int ADDR_W   = 4;
  localparam int AF_LEVEL = 12;
  localparam int DEPTH    = 16;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W:0]   rptr_gray;
  logic [ADDR_W:0]   wptr_gray;
  logic [ADDR_W-1:0] waddr;
  logic              wr_accept;
  logic              full;
  logic              almost_full;
  logic [ADDR_W:0]   wr_level;
  logic              overflow;

  fifo_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rptr_gray   (rptr_gray),
    .wptr_gray   (wptr_gray),
    .waddr       (waddr),
    .wr_accept   (wr_accept),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_wcount;     // writes accepted since reset
  int m_rcount;     // reads performed by the (virtual) read side
  int m_hist[$];    // read count offered at the most recent edges
  bit m_full;
  bit m_af;
  int m_level;
  bit m_ovf;

  function automatic logic [ADDR_W:0] gray_of(input int n);
    int m;
    m = n % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  task automatic model_reset();
    m_wcount = 0;
    m_rcount = 0;
    m_hist.delete();
    m_full  = 1'b0;
    m_af    = 1'b0;
    m_level = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock: drive inputs at negedge, check wr_accept, advance the model
  // at posedge, check registered outputs shortly after.
  task automatic cycle(input bit we, input bit rd);
    bit acc;
    bit ovf_set;
    int seen;
    @(negedge clk);
    wr_en = we;
    if (rd && (m_rcount < m_wcount)) m_rcount++;
    rptr_gray = gray_of(m_rcount);
    acc     = we && !m_full;
    ovf_set = we && m_full;
    #1;
    checks++;
    if (wr_accept !== acc) begin
      errors++;
      $display("FAIL cyc_wr_accept: got %b want %b", wr_accept, acc);
    end
    @(posedge clk);
    m_hist.push_back(m_rcount);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    seen = (m_hist.size() == 3) ? m_hist[0] : 0;
    if (acc) m_wcount++;
    m_level = m_wcount - seen;
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= AF_LEVEL);
    if (ovf_set) m_ovf = 1'b1;
    #1;
    checks++;
    if (waddr !== 4'(m_wcount % 16)) begin
      errors++;
      $display("FAIL cyc_waddr: got %0d want %0d", waddr, m_wcount % 16);
    end
    checks++;
    if (wptr_gray !== gray_of(m_wcount)) begin
      errors++;
      $display("FAIL cyc_wptr_gray: got %b want %b", wptr_gray, gray_of(m_wcount));
    end
    checks++;
    if (wr_level !== 5'(m_level)) begin
      errors++;
      $display("FAIL cyc_wr_level: got %0d want %0d", wr_level, m_level);
    end
    checks++;
    if (full !== m_full) begin
      errors++;
      $display("FAIL cyc_full: got %b want %b", full, m_full);
    end
    checks++;
    if (almost_full !== m_af) begin
      errors++;
      $display("FAIL cyc_almost_full: got %b want %b", almost_full, m_af);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL cyc_overflow: got %b want %b", overflow, m_ovf);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    wr_en     = 1'b0;
    rptr_gray = '0;
    rst       = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    rptr_gray = '0;
    model_reset();
    apply_reset();
    #1;
    checks++;
    if ({wptr_gray, waddr, full, almost_full, wr_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got g=%b a=%0d f=%b af=%b l=%0d o=%b want all zero",
               wptr_gray, waddr, full, almost_full, wr_level, overflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0);
      checks++;
      if (almost_full !== (i >= AF_LEVEL)) begin
        errors++;
        $display("FAIL fill_af_at_%0d: got %b want %b", i, almost_full, i >= AF_LEVEL);
      end
    end
    checks++;
    if (full !== 1'b1 || wr_level !== 5'd16) begin
      errors++;
      $display("FAIL fill_full: got full=%b level=%0d want full=1 level=16", full, wr_level);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0);
    checks++;
    if (waddr !== 4'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got waddr=%0d ovf=%b want waddr=0 ovf=1", waddr, overflow);
    end
    repeat (3) cycle(1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_read_latency();
    // read presented at edge k
    cycle(1'b0, 1'b1);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat_k: got full=%b want 1", full);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || wr_level !== 5'd16) begin
      errors++;
      $display("FAIL rd_lat_k1: got full=%b level=%0d want full=1 level=16", full, wr_level);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (full !== 1'b0 || wr_level !== 5'd15) begin
      errors++;
      $display("FAIL rd_lat_k2: got full=%b level=%0d want full=0 level=15", full, wr_level);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    repeat (10) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    // read offered two edges ahead so it lands together with the write
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    checks++;
    if (wr_level !== 5'd10) begin
      errors++;
      $display("FAIL simul_level: got %0d want 10", wr_level);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W:0] prev;
    int writes;
    apply_reset();
    writes = 0;
    prev = wptr_gray;
    for (int n = 0; n < 400 && writes < 60; n++) begin
      bit we;
      we = ($urandom_range(0, 9) < 8);
      cycle(we, $urandom_range(0, 9) < 7);
      if (wptr_gray !== prev) begin
        writes++;
        checks++;
        if ($countones(wptr_gray ^ prev) != 1) begin
          errors++;
          $display("FAIL rand_gray_step: got %b -> %b want one-bit change", prev, wptr_gray);
        end
      end
      prev = wptr_gray;
    end
    checks++;
    if (writes < 40) begin
      errors++;
      $display("FAIL rand_write_count: got %0d want >= 40", writes);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    repeat (7) cycle(1'b1, 1'b0);
    checks++;
    if (wr_level !== 5'd7) begin
      errors++;
      $display("FAIL midrst_level: got %0d want 7", wr_level);
    end
    @(negedge clk);
    wr_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wptr_gray, waddr, full, almost_full, wr_level, overflow} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got g=%b a=%0d l=%0d want all zero", wptr_gray, waddr, wr_level);
    end
    model_reset();
    wr_en = 1'b0;
    rptr_gray = '0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 1'b0);
    checks++;
    if (waddr !== 4'd1 || wr_level !== 5'd1) begin
      errors++;
      $display("FAIL midrst_first_write: got waddr=%0d level=%0d want 1 1 after write to 0",
               waddr, wr_level);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_latency();
    test_simultaneous();
    test_random();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_wr_ctrl
`default_nettype wire
